cpu_out_uart_tx: RTL and testbench
==================================

# cpu_out_uart_tx

Memory-mapped output peripheral that sits on the far side of the CPU's I/O word at address 0x7FFFFFFC. Each CPU store to that address delivers a 32-bit word, which this block queues and serializes onto an asynchronous 8N1 serial line, least-significant byte first. A status word fed back into the CPU's input port lets software poll for space before storing.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, word FIFO depth; power of two, 2..8.

- CLK  in  1  system clock, rising edge.
- Reset  in  1  reset: one clock; reset is asynchronous and active-low (0 = reset).
- CPUOut  in  32  store data from the CPU's I/O store path.
- IOWrite  in  1  one-cycle strobe; high = CPUOut valid this edge (CPU I/O write enable).
- IORead  in  1  one-cycle strobe; high = CPU is loading the status word.
- StatusOut  out  32  status word, routed to the CPU input port.
- TxD  out  1  serial output, idle high.
- Busy  out  1  high while FIFO non-empty or a frame is in progress.

## Operation
- FIFO: FIFO_DEPTH x 32 words, count 0..FIFO_DEPTH, registered read/write pointers wrapping modulo FIFO_DEPTH.
- Push: IOWrite=1 at an edge with space -> CPUOut written at write pointer, count+1.
- Full: IOWrite=1 with count==FIFO_DEPTH and no pop at the same edge -> word dropped, Overflow set. With a pop at the same edge -> word accepted, count unchanged.
- Overflow: sticky. Cleared at an edge where IORead=1. If IORead and a dropping write coincide, set wins.
- StatusOut: bit0 Full (count==FIFO_DEPTH), bit1 Busy, bit2 Overflow, bits[7:4] count, all other bits 0. Combinational from registers.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If count>0, pop head into the 32-bit shift register, byte index=0, go to START.
  - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: TxD=current byte bit[bit index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles. Then:
    - byte index<3: shift the register right by 8, byte index+1, go to START.
    - byte index==3 and count>0: pop the next word and go directly to START.
    - otherwise: go to IDLE.
- Byte order on the line: word[7:0], [15:8], [23:16], [31:24].
- Bit counter: 0..CLKS_PER_BIT-1, 16 bits wide.

## Timing
- Reset asserted (async): TxD=1, Busy=0, StatusOut=0, FIFO empty, Overflow=0, FSM=IDLE, all counters 0. Takes effect immediately, including mid-frame; the partial frame is abandoned and never resumed.
- Reset release: the first active edge is the first edge with Reset=1.
- Latency:
  - IOWrite at edge k -> count/Busy update after edge k.
  - Pop and START at edge k+1 -> TxD falls after edge k+1.
- Frame = 10*CLKS_PER_BIT cycles. Word = 40*CLKS_PER_BIT cycles with no idle gap between bytes.
- Back-to-back words: no idle cycles between the last stop bit of one word and the next start bit.
- Pop at the same edge as a push into an empty FIFO is not possible. The word must be registered first, so the minimum latency is one edge.
- Busy falls at the edge that ends the final stop bit with an empty FIFO.

## Test plan
- CLKS_PER_BIT=4: after reset, IOWrite with CPUOut=0x000000A5.
  - TxD is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - Three further frames of 0x00 follow; each frame is start bit 0, eight data bits 0, stop bit 1.
  - Busy stays high for 160 cycles, then falls; StatusOut=0 afterward.
- Write 0x44332211: the received byte sequence is 0x11, 0x22, 0x33, 0x44 with no gaps.
- FIFO_DEPTH=4: with TX busy, write 5 words in consecutive cycles.
  - Fifth word is dropped; StatusOut shows bit2=1, bit0=1, count=4.
  - IORead -> bit2 clears next cycle.
  - Only the 4 accepted words appear on TxD.
- FIFO full: push a word at the exact edge where STOP of byte 3 pops the head.
  - The word is accepted, count stays 4, and Overflow stays 0.
- Assert Reset mid-DATA of byte 2.
  - TxD=1 and StatusOut=0 immediately, with no clock edge needed.
  - After release, a new write 0x000000FF transmits cleanly.
- IORead and a dropping IOWrite on the same edge: Overflow remains 1.

Source files
------------

// File: rtl/cpu_out_uart_tx.sv
// CPU store-port UART transmitter: a small word FIFO feeding an 8N1 serializer
// that sends each 32-bit word least-significant byte first.
module cpu_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] CPUOut,
    input  logic        IOWrite,
    input  logic        IORead,
    output logic [31:0] StatusOut,
    output logic        TxD,
    output logic        Busy
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] CLK_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  DEPTH_C  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t        state_q, state_d;
    logic [15:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shift_q, shift_d;

    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic          not_empty;
    logic          bit_done;

    assign full      = (count_q == DEPTH_C);
    assign not_empty = (count_q != 4'd0);
    assign bit_done  = (clk_cnt_q == CLK_LAST);

    // A write into a full FIFO still lands if the serializer frees a slot on the same edge.
    assign push = IOWrite && (!full || pop);
    assign drop = IOWrite && full && !pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + {3'b000, push} - {3'b000, pop};
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (IORead) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = bit_done ? 16'd0 : clk_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        TxD        = 1'b1;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = 16'd0;
                if (not_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                TxD = 1'b0;
                if (bit_done) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                TxD = shift_q[bit_idx_q];
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != 2'd3) begin
                        shift_d    = {8'h00, shift_q[31:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                    end else if (not_empty) begin
                        // Chain straight into the next word so the line never idles.
                        pop        = 1'b1;
                        shift_d    = mem_q[rd_ptr_q];
                        byte_idx_d = 2'd0;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= CPUOut;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            clk_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

    assign Busy      = not_empty || (state_q != S_IDLE);
    assign StatusOut = {24'd0, count_q, 1'b0, overflow_q, Busy, full};

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx: a line receiver checks bytes against a
// queue of expected bytes, and status/timing points are checked inline.
module tb_cpu_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_out;
    logic        io_write;
    logic        io_read;
    logic [31:0] status;
    logic        txd;
    logic        busy;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic [7:0]  exp_q[$];
    int          rx_starts[$];
    logic        rx_active;
    int          rx_cnt;
    logic [7:0]  rx_byte;

    cpu_out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK      (clk),
        .Reset    (rst_n),
        .CPUOut   (cpu_out),
        .IOWrite  (io_write),
        .IORead   (io_read),
        .StatusOut(status),
        .TxD      (txd),
        .Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serial receiver: samples mid-bit on falling clock edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
            rx_cnt    = 0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_byte[(rx_cnt / CPB) - 1] = txd;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                chk("rx_stop_bit", {31'd0, txd}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL rx_unexpected_byte observed=%h expected=none", rx_byte);
                end else begin
                    chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
                $display("rx byte %h at cycle %0d", rx_byte, cyc);
                rx_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
    endtask

    task automatic write_word(input logic [31:0] w);
        cpu_out  = w;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        $display("write %h at cycle %0d", w, cyc);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || rx_active || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        logic [7:0]  b;
        logic        e;
        int          p;
        int          slot;
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        rx_active = 1'b0;
        rx_cnt   = 0;
        rx_byte  = 8'd0;
        cpu_out  = 32'd0;
        io_write = 1'b0;
        io_read  = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_status", status, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_status", status, 32'd0);

        // Single word 0xA5: exact line waveform over four frames.
        expect_word(32'h0000_00A5);
        write_word(32'h0000_00A5);
        chk("a5_status_after_push", status, 32'h12);
        chk("a5_txd_before_pop", {31'd0, txd}, 32'd1);
        for (int c = 0; c < 40 * CPB; c++) begin
            tick();
            b    = (c < 10 * CPB) ? 8'hA5 : 8'h00;
            slot = (c % (10 * CPB)) / CPB;
            if (slot == 0) e = 1'b0;
            else if (slot == 9) e = 1'b1;
            else e = b[slot - 1];
            chk($sformatf("a5_wave_c%0d", c), {31'd0, txd}, {31'd0, e});
        end
        chk("a5_busy_last_stop", {31'd0, busy}, 32'd1);
        tick();
        chk("a5_busy_done", {31'd0, busy}, 32'd0);
        chk("a5_status_done", status, 32'd0);
        wait_drain("a5_drain", 50);

        // Byte order and gapless bytes.
        rx_starts.delete();
        expect_word(32'h4433_2211);
        write_word(32'h4433_2211);
        wait_drain("order_drain", 400);
        chk("order_frames", rx_starts.size(), 32'd4);
        for (int i = 1; i < 4 && i < rx_starts.size(); i++)
            chk($sformatf("order_gap%0d", i), rx_starts[i] - rx_starts[i-1], 10 * CPB);

        // Overflow with TX busy: five writes back to back, fifth dropped.
        expect_word(32'hA0A0_A0A0);
        write_word(32'hA0A0_A0A0);
        tick();
        p = cyc;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_word(32'h1111_1111 * i);
            write_word(32'h1111_1111 * i);
        end
        chk("ovf_status", status, 32'h47);
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
        chk("ovf_cleared", status, 32'h43);
        io_read  = 1'b1;
        cpu_out  = 32'hDEAD_BEEF;
        io_write = 1'b1;
        tick();
        io_read  = 1'b0;
        io_write = 1'b0;
        chk("ovf_set_wins", status, 32'h47);
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
        chk("ovf_cleared2", status, 32'h43);

        // Push exactly on the edge that pops the next head.
        while (cyc < p + 40 * CPB - 1) tick();
        expect_word(32'h6666_6666);
        write_word(32'h6666_6666);
        chk("popedge_status", status, 32'h43);
        wait_drain("ovf_drain", 1200);

        // Reset in the middle of byte 2's data bits.
        expect_word(32'h1234_5678);
        write_word(32'h1234_5678);
        for (int i = 0; i < 25 * CPB - 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_txd", {31'd0, txd}, 32'd1);
        chk("midreset_status", status, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_pending", exp_q.size(), 32'd2);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_reset_status", status, 32'd0);
        chk("after_reset_txd", {31'd0, txd}, 32'd1);
        expect_word(32'h0000_00FF);
        write_word(32'h0000_00FF);
        wait_drain("ff_drain", 400);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
